slow_clock_monitor: RTL and testbench

Receive-side companion to the team's clock divider. It samples a slow divided clock, such as a divider's clk_out, in the fast clk_in domain and synchronizes it. It emits single-cycle rise/fall strobes, measures each half-period in clk_in cycles, and maintains a lock/fault state against an expected half-period. FIFO-side logic uses it to get clean enable pulses and a health indication instead of clocking registers from the divided clock directly.

---
 rtl/slow_clock_monitor.sv | 110 +++++++++++
 tb/tb_slow_clock_monitor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor: synchronizes a slow divided clock, emits edge strobes, measures half-periods and tracks lock/fault health
module slow_clock_monitor #(
    parameter int EXP_HALF   = 500000000,
    parameter int TOL        = 16,
    parameter int LOCK_COUNT = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_clk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             too_fast,
    output logic             too_slow,
    output logic             stalled,
    output logic             locked,
    output logic [1:0]       state,
    output logic [7:0]       fault_count
);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W:0] HI = (CNT_W+1)'(EXP_HALF + TOL);
    localparam logic [CNT_W:0] LO = (CNT_W+1)'(EXP_HALF > TOL ? EXP_HALF - TOL : 0);

    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCKED = 2'd2, FAULT = 2'd3} state_t;

    state_t st, st_nx;
    logic s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [RUN_W-1:0] run, run_nx;
    logic [CNT_W:0] meas;
    logic edge_ev, good, stall, measure;

    // meas is cnt+1, one bit wider so the stall compare never wraps
    assign meas    = {1'b0, cnt} + (CNT_W+1)'(1);
    assign edge_ev = s2 ^ s3;
    assign good    = meas >= LO && meas <= HI;
    assign stall   = (st == ACQ || st == LOCKED) && !edge_ev && meas > HI;
    assign measure = edge_ev && (st == ACQ || st == LOCKED);
    assign state   = st;
    assign locked  = st == LOCKED;

    // two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk_in or posedge reset)
        if (reset) {s1, s2, s3} <= 3'b000;
        else       {s1, s2, s3} <= {slow_clk, s1, s2};

    // edge-to-edge interval counter, held in IDLE, saturating at all-ones
    always_ff @(posedge clk_in or posedge reset)
        if (reset)                      cnt <= '0;
        else if (st == IDLE || edge_ev) cnt <= '0;
        else if (~&cnt)                 cnt <= meas[CNT_W-1:0];

    // state and good-run registers
    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            st  <= IDLE;
            run <= '0;
        end else begin
            st  <= st_nx;
            run <= run_nx;
        end

    // next state: the first edge after IDLE/FAULT only restarts acquisition
    always_comb begin
        st_nx  = st;
        run_nx = run;
        case (st)
            IDLE: if (edge_ev) begin
                st_nx  = ACQ;
                run_nx = '0;
            end
            ACQ: if (edge_ev) begin
                run_nx = good ? run + RUN_W'(1) : '0;
                if (good && run_nx == RUN_W'(LOCK_COUNT)) st_nx = LOCKED;
            end else if (stall) st_nx = FAULT;
            LOCKED: if ((edge_ev && !good) || stall) st_nx = FAULT;
            FAULT: if (edge_ev) begin
                st_nx  = ACQ;
                run_nx = '0;
            end
        endcase
    end

    // registered strobes, measurement results, stall flag and fault counter
    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            period_valid <= 1'b0;
            half_period  <= '0;
            too_fast     <= 1'b0;
            too_slow     <= 1'b0;
            stalled      <= 1'b0;
            fault_count  <= 8'd0;
        end else begin
            rise_pulse   <= edge_ev && s2;
            fall_pulse   <= edge_ev && !s2;
            period_valid <= measure;
            if (measure) begin
                half_period <= meas[CNT_W-1:0];
                too_fast    <= meas < LO;
                too_slow    <= meas > HI;
            end
            if (edge_ev)    stalled <= 1'b0;
            else if (stall) stalled <= 1'b1;
            if (st_nx == FAULT && st != FAULT && fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
        end
endmodule

// File: tb/tb_slow_clock_monitor.sv
// tb_slow_clock_monitor: directed and randomized slow-clock waveforms checked against a timestamp-based reference model
module tb_slow_clock_monitor;
    localparam int EXP = 10, TOL = 1, LOCKN = 2, W = 8;
    localparam int HI = EXP + TOL, LO = EXP - TOL;

    logic clk_in = 1'b0, reset = 1'b1, slow_clk = 1'b0;
    logic rise_pulse, fall_pulse, period_valid, too_fast, too_slow, stalled, locked;
    logic [W-1:0] half_period;
    logic [1:0] state;
    logic [7:0] fault_count;

    int errors = 0, checks = 0;

    // reference model: sampled-input history, edge timestamps and spec-level state
    int d[4];
    int k, last_ev, m_st, m_run, m_half, m_fc;
    bit m_rp, m_fp, m_pv, m_tf, m_ts, m_stl;

    slow_clock_monitor #(.EXP_HALF(EXP), .TOL(TOL), .LOCK_COUNT(LOCKN), .CNT_W(W)) dut (
        .clk_in(clk_in), .reset(reset), .slow_clk(slow_clk),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .half_period(half_period),
        .period_valid(period_valid), .too_fast(too_fast), .too_slow(too_slow),
        .stalled(stalled), .locked(locked), .state(state), .fault_count(fault_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("rise_pulse", rise_pulse, m_rp);
        check("fall_pulse", fall_pulse, m_fp);
        check("period_valid", period_valid, m_pv);
        check("half_period", half_period, m_half);
        check("too_fast", too_fast, m_tf);
        check("too_slow", too_slow, m_ts);
        check("stalled", stalled, m_stl);
        check("locked", locked, m_st == 2);
        check("state", state, m_st);
        check("fault_count", fault_count, m_fc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) d[i] = 0;
        k = 0; last_ev = 0; m_st = 0; m_run = 0; m_half = 0; m_fc = 0;
        m_rp = 0; m_fp = 0; m_pv = 0; m_tf = 0; m_ts = 0; m_stl = 0;
    endtask

    // an input change sampled at edge j is seen as a synchronized edge at edge j+2
    task automatic model_step();
        bit ev, gd, stl_c;
        int m, ns;
        d[3] = d[2]; d[2] = d[1]; d[1] = d[0]; d[0] = int'(slow_clk);
        k++;
        ev = d[2] != d[3];
        m = k - last_ev;
        gd = m >= LO && m <= HI;
        stl_c = (m_st == 1 || m_st == 2) && !ev && m > HI;
        m_rp = ev && d[2] == 1;
        m_fp = ev && d[2] == 0;
        m_pv = ev && (m_st == 1 || m_st == 2);
        ns = m_st;
        if (m_st == 0 || m_st == 3) begin
            if (ev) begin ns = 1; m_run = 0; end
        end else if (ev) begin
            if (!gd) begin
                m_run = 0;
                if (m_st == 2) ns = 3;
            end else if (m_st == 1) begin
                m_run = m_run + 1;
                if (m_run >= LOCKN) ns = 2;
            end
        end else if (stl_c) ns = 3;
        if (m_pv) begin m_half = m; m_tf = m < LO; m_ts = m > HI; end
        if (ev) m_stl = 0;
        else if (stl_c) m_stl = 1;
        if (ns == 3 && m_st != 3 && m_fc < 255) m_fc++;
        if (ev) last_ev = k;
        m_st = ns;
    endtask

    task automatic cyc();
        @(posedge clk_in);
        if (!reset) model_step();
        #1 check_all();
    endtask

    task automatic half(input int n);
        slow_clk = ~slow_clk;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    initial begin
        int r, n;
        model_reset();
        repeat (2) cyc();
        reset = 1'b0;
        // nominal 10-cycle halves: acquire and lock
        repeat (6) half(10);
        check("locked_nominal", locked, 1);
        // one short half forces FAULT, then re-acquire
        half(8);
        repeat (4) half(10);
        check("locked_after_fast", locked, 1);
        check("faults_after_fast", fault_count, 1);
        // hold slow_clk to stall, then recover
        half(20);
        check("stalled_hold", stalled, 1);
        half(10);
        check("state_after_stall", state, 1);
        repeat (2) half(10);
        // edge-of-tolerance halves keep lock
        repeat (8) begin half(11); half(9); end
        check("locked_tol", locked, 1);
        check("too_fast_tol", too_fast, 0);
        check("too_slow_tol", too_slow, 0);
        // reset while locked with slow_clk high
        if (!slow_clk) half(10);
        do_reset();
        repeat (6) cyc();
        check("state_after_reset", state, 1);
        // randomized half-periods with occasional resets
        repeat (250) begin
            r = $urandom_range(0, 19);
            if (r == 0) do_reset();
            else begin
                if (r <= 10)      n = $urandom_range(9, 11);
                else if (r <= 12) n = ($urandom_range(0, 1) != 0) ? 8 : 12;
                else if (r <= 14) n = $urandom_range(1, 3);
                else if (r <= 16) n = $urandom_range(13, 20);
                else              n = $urandom_range(4, 7);
                half(n);
            end
        end
        // repeated stalls drive fault_count into saturation
        repeat (300) half(14);
        check("fault_sat", fault_count, 255);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
